// File: rtl/kmeans_centroid_update_k3n2_if.sv
// Bundles the start/status, current-centroid, accumulator-read and centroid-write
// signals of the 3-centroid, 2-dimension k-means centroid updater.
interface kmeans_centroid_update_k3n2_if #(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16
);
    logic                                start;
    logic [input_data_width-1:0]         cur_k0d0;
    logic [input_data_width-1:0]         cur_k0d1;
    logic [input_data_width-1:0]         cur_k1d0;
    logic [input_data_width-1:0]         cur_k1d1;
    logic [input_data_width-1:0]         cur_k2d0;
    logic [input_data_width-1:0]         cur_k2d1;

    logic                                rd_acc_en;
    logic [1:0]                          rd_acc_centroid;
    logic [acc_width-1:0]                acc0_in;
    logic [acc_width-1:0]                acc1_in;
    logic [input_data_qty_bit_width-1:0] acc_counter_in;

    logic                                centroid_wr;
    logic [1:0]                          centroid_wr_idx;
    logic [input_data_width-1:0]         centroid_wr_d0;
    logic [input_data_width-1:0]         centroid_wr_d1;

    logic                                busy;
    logic                                done;
    logic                                converged;

    modport master (
        input  start, cur_k0d0, cur_k0d1, cur_k1d0, cur_k1d1, cur_k2d0, cur_k2d1,
        input  acc0_in, acc1_in, acc_counter_in,
        output rd_acc_en, rd_acc_centroid,
        output centroid_wr, centroid_wr_idx, centroid_wr_d0, centroid_wr_d1,
        output busy, done, converged
    );

    modport slave (
        output start, cur_k0d0, cur_k0d1, cur_k1d0, cur_k1d1, cur_k2d0, cur_k2d1,
        output acc0_in, acc1_in, acc_counter_in,
        input  rd_acc_en, rd_acc_centroid,
        input  centroid_wr, centroid_wr_idx, centroid_wr_d0, centroid_wr_d1,
        input  busy, done, converged
    );
endinterface

// File: rtl/kmeans_centroid_update_k3n2.sv
// Recomputes 3 two-dimensional centroids as floor(sum/count) using a shared
// restoring divider that handles both dimensions in parallel.
module kmeans_centroid_update_k3n2 #(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16
) (
    input logic                    clk,
    input logic                    rst,
    kmeans_centroid_update_k3n2_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, DIV, WRITE, DONE} state_t;

    localparam int cnt_width = $clog2(acc_width);
    localparam logic [cnt_width-1:0] last_step = cnt_width'(acc_width - 1);
    localparam logic [acc_width-1:0] max_coord =
        {{(acc_width - input_data_width){1'b0}}, {input_data_width{1'b1}}};

    state_t                      state;
    logic [1:0]                  k;
    logic                        changed;
    logic [cnt_width-1:0]        div_cnt;
    logic [acc_width-1:0]        divisor;
    logic [acc_width-1:0]        rem0, rem1, quo0, quo1;

    logic                        rd_acc_en, centroid_wr, busy, done, converged;
    logic [1:0]                  rd_acc_centroid, centroid_wr_idx;
    logic [input_data_width-1:0] wr_d0, wr_d1;

    logic [input_data_width-1:0] cur_d0, cur_d1, new_d0, new_d1;
    logic [acc_width:0]          trial0, trial1, div_ext;
    logic                        ge0, ge1, enter_write;
    logic [acc_width-1:0]        rem0_nxt, rem1_nxt, quo0_nxt, quo1_nxt;

    function automatic logic [input_data_width-1:0] saturate(input logic [acc_width-1:0] q);
        if (q > max_coord) return '1;
        return q[input_data_width-1:0];
    endfunction

    always_comb begin
        cur_d0 = bus.cur_k0d0;
        cur_d1 = bus.cur_k0d1;
        case (k)
            2'd1: begin cur_d0 = bus.cur_k1d0; cur_d1 = bus.cur_k1d1; end
            2'd2: begin cur_d0 = bus.cur_k2d0; cur_d1 = bus.cur_k2d1; end
            default: ;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits; the quotient bit shifts into quo.
    always_comb begin
        div_ext  = {1'b0, divisor};
        trial0   = {rem0, quo0[acc_width-1]};
        trial1   = {rem1, quo1[acc_width-1]};
        ge0      = trial0 >= div_ext;
        ge1      = trial1 >= div_ext;
        rem0_nxt = ge0 ? acc_width'(trial0 - div_ext) : trial0[acc_width-1:0];
        rem1_nxt = ge1 ? acc_width'(trial1 - div_ext) : trial1[acc_width-1:0];
        quo0_nxt = {quo0[acc_width-2:0], ge0};
        quo1_nxt = {quo1[acc_width-2:0], ge1};
    end

    always_comb begin
        enter_write = ((state == READ) && (bus.acc_counter_in == '0)) ||
                      ((state == DIV) && (div_cnt == last_step));
        new_d0 = cur_d0;
        new_d1 = cur_d1;
        if (state == DIV) begin
            new_d0 = saturate(quo0_nxt);
            new_d1 = saturate(quo1_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            k               <= '0;
            changed         <= 1'b0;
            div_cnt         <= '0;
            divisor         <= '0;
            rem0            <= '0;
            rem1            <= '0;
            quo0            <= '0;
            quo1            <= '0;
            rd_acc_en       <= 1'b0;
            rd_acc_centroid <= '0;
            centroid_wr     <= 1'b0;
            centroid_wr_idx <= '0;
            wr_d0           <= '0;
            wr_d1           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            converged       <= 1'b0;
        end else begin
            // NOTE: strobes fall back to 0 every cycle; only the entering state raises them.
            rd_acc_en   <= 1'b0;
            centroid_wr <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state           <= READ;
                        k               <= '0;
                        changed         <= 1'b0;
                        busy            <= 1'b1;
                        rd_acc_en       <= 1'b1;
                        rd_acc_centroid <= '0;
                    end
                end
                READ: begin
                    divisor <= acc_width'(bus.acc_counter_in);
                    quo0    <= bus.acc0_in;
                    quo1    <= bus.acc1_in;
                    rem0    <= '0;
                    rem1    <= '0;
                    div_cnt <= '0;
                    state   <= (bus.acc_counter_in != '0) ? DIV : WRITE;
                end
                DIV: begin
                    rem0    <= rem0_nxt;
                    rem1    <= rem1_nxt;
                    quo0    <= quo0_nxt;
                    quo1    <= quo1_nxt;
                    div_cnt <= div_cnt + cnt_width'(1);
                    if (div_cnt == last_step) state <= WRITE;
                end
                WRITE: begin
                    if (k == 2'd2) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        converged <= ~changed;
                    end else begin
                        state           <= READ;
                        k               <= k + 2'd1;
                        rd_acc_en       <= 1'b1;
                        rd_acc_centroid <= k + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // The change flag is folded in with the write data so it is final by DONE.
            if (enter_write) begin
                centroid_wr     <= 1'b1;
                centroid_wr_idx <= k;
                wr_d0           <= new_d0;
                wr_d1           <= new_d1;
                changed         <= changed | (new_d0 != cur_d0) | (new_d1 != cur_d1);
            end
        end
    end

    assign bus.rd_acc_en       = rd_acc_en;
    assign bus.rd_acc_centroid = rd_acc_centroid;
    assign bus.centroid_wr     = centroid_wr;
    assign bus.centroid_wr_idx = centroid_wr_idx;
    assign bus.centroid_wr_d0  = wr_d0;
    assign bus.centroid_wr_d1  = wr_d1;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.converged       = converged;
endmodule
